// File: rtl/pipe_stage_buf.sv
// Generic in-order pipeline stage buffer with valid/ready handshake, flush and occupancy report.
// Defining PIPE_STAGE_BUF_STATS_EN adds saturating stall_cycles/flush_count statistics outputs.
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic [CNT_W-1:0]             flush_count
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_count;
    logic [OCC_W-1:0]  w_count_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH-1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign w_full    = (r_count == OCC_W'(DEPTH));
    assign w_empty   = (r_count == OCC_W'(0));
    assign in_ready  = rst & ~w_full & ~flush;
    assign out_valid = ~w_empty;
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Next occupancy; flush overrides any concurrent transfer.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + OCC_W'(1);
                2'b01:   w_count_nxt = r_count - OCC_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage, pointers and occupancy state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
            end
            r_count <= w_count_nxt;
        end
    end

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] n;
        if (&v) begin
            n = v;
        end else begin
            n = v + CNT_W'(1);
        end
        return n;
    endfunction

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
            if (flush && !w_empty) begin
                r_flush_count <= sat_inc(r_flush_count);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf with DEPTH=2, DEPTH=3 and DEPTH=1 instances.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic f2, iv2, or2, ir2, ov2, fu2, em2;
    logic [7:0] id2, od2;
    logic [1:0] cn2;
    logic f3, iv3, or3, ir3, ov3, fu3, em3;
    logic [7:0] id3, od3;
    logic [1:0] cn3;
    logic f1, iv1, or1, ir1, ov1, fu1, em1;
    logic [7:0] id1, od1;
    logic [0:0] cn1;
`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [1:0] st2, fc2, st3, fc3, st1, fc1;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(8), .DEPTH(2)
`ifdef PIPE_STAGE_BUF_STATS_EN
        , .CNT_W(2)
`endif
    ) u2 (
        .clk(clk), .rst(rst), .flush(f2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cn2), .full(fu2), .empty(em2)
`ifdef PIPE_STAGE_BUF_STATS_EN
        , .stall_cycles(st2), .flush_count(fc2)
`endif
    );

    pipe_stage_buf #(.DATA_W(8), .DEPTH(3)
`ifdef PIPE_STAGE_BUF_STATS_EN
        , .CNT_W(2)
`endif
    ) u3 (
        .clk(clk), .rst(rst), .flush(f3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cn3), .full(fu3), .empty(em3)
`ifdef PIPE_STAGE_BUF_STATS_EN
        , .stall_cycles(st3), .flush_count(fc3)
`endif
    );

    pipe_stage_buf #(.DATA_W(8), .DEPTH(1)
`ifdef PIPE_STAGE_BUF_STATS_EN
        , .CNT_W(2)
`endif
    ) u1 (
        .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cn1), .full(fu1), .empty(em1)
`ifdef PIPE_STAGE_BUF_STATS_EN
        , .stall_cycles(st1), .flush_count(fc1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (cn2 !== 2'd0) begin n_err++; $display("FAIL rst_count got %0h exp 0", cn2); end
        n_cmp++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b exp 0", ov2); end
        n_cmp++; if (od2 !== 8'h00) begin n_err++; $display("FAIL rst_out_data got %0h exp 0", od2); end
        n_cmp++; if (em2 !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0b exp 1", em2); end
        n_cmp++; if (fu2 !== 1'b0) begin n_err++; $display("FAIL rst_full got %0b exp 0", fu2); end
        n_cmp++; if (ir2 !== 1'b0) begin n_err++; $display("FAIL rst_in_ready_low got %0b exp 0", ir2); end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (ir2 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_release got %0b exp 1", ir2); end
        iv2 = 1'b1; id2 = 8'h11; or2 = 1'b0;
        tick();
        id2 = 8'h22;
        tick();
        iv2 = 1'b0;
        n_cmp++; if (cn2 !== 2'd2) begin n_err++; $display("FAIL midrst_filled got %0h exp 2", cn2); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (cn2 !== 2'd0) begin n_err++; $display("FAIL midrst_count got %0h exp 0", cn2); end
        n_cmp++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %0b exp 0", ov2); end
        n_cmp++; if (od2 !== 8'h00) begin n_err++; $display("FAIL midrst_out_data got %0h exp 0", od2); end
        n_cmp++; if (ir2 !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready got %0b exp 0", ir2); end
        @(posedge clk);
        #1 rst = 1'b1; or2 = 1'b1;
        #1;
        n_cmp++; if (ir2 !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready_release got %0b exp 1", ir2); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL midrst_stale_beat got valid=%0b data=%0h exp valid 0", ov2, od2); end
        end
    endtask

    task automatic test_streaming();
        or2 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv2 = 1'b1; id2 = 8'(i);
            n_cmp++; if (ir2 !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", i, ir2); end
            tick();
            n_cmp++; if (ov2 !== 1'b1 || od2 !== 8'(i)) begin n_err++; $display("FAIL stream_out[%0d] got valid=%0b data=%0h exp valid=1 data=%0h", i, ov2, od2, i); end
            n_cmp++; if (cn2 !== 2'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0h exp 1", i, cn2); end
        end
        iv2 = 1'b0;
        tick();
        n_cmp++; if (em2 !== 1'b1) begin n_err++; $display("FAIL stream_drain got empty=%0b exp 1", em2); end
    endtask

    task automatic test_backpressure();
        or2 = 1'b0; iv2 = 1'b1; id2 = 8'h0A;
        tick();
        id2 = 8'h0B;
        tick();
        id2 = 8'h0C;
        n_cmp++; if (fu2 !== 1'b1 || cn2 !== 2'd2) begin n_err++; $display("FAIL bp_full got full=%0b count=%0h exp full=1 count=2", fu2, cn2); end
        n_cmp++; if (ir2 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %0b exp 0", ir2); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ov2 !== 1'b1 || od2 !== 8'h0A || cn2 !== 2'd2) begin n_err++; $display("FAIL bp_hold[%0d] got valid=%0b data=%0h count=%0h exp 1/0a/2", i, ov2, od2, cn2); end
        end
        or2 = 1'b1;
        tick();
        n_cmp++; if (od2 !== 8'h0B || cn2 !== 2'd1) begin n_err++; $display("FAIL bp_release_b got data=%0h count=%0h exp 0b/1", od2, cn2); end
        tick();
        iv2 = 1'b0;
        n_cmp++; if (od2 !== 8'h0C || cn2 !== 2'd1) begin n_err++; $display("FAIL bp_release_c got data=%0h count=%0h exp 0c/1", od2, cn2); end
        tick();
        n_cmp++; if (em2 !== 1'b1) begin n_err++; $display("FAIL bp_drain got empty=%0b exp 1", em2); end
    endtask

    task automatic test_push_pop();
        or2 = 1'b0; iv2 = 1'b1; id2 = 8'h0D;
        tick();
        n_cmp++; if (od2 !== 8'h0D || cn2 !== 2'd1) begin n_err++; $display("FAIL pp_first got data=%0h count=%0h exp 0d/1", od2, cn2); end
        id2 = 8'h0E; or2 = 1'b1;
        tick();
        iv2 = 1'b0;
        n_cmp++; if (od2 !== 8'h0E || cn2 !== 2'd1) begin n_err++; $display("FAIL pp_both got data=%0h count=%0h exp 0e/1", od2, cn2); end
        tick();
        n_cmp++; if (em2 !== 1'b1) begin n_err++; $display("FAIL pp_drain got empty=%0b exp 1", em2); end
    endtask

    task automatic test_flush();
        or2 = 1'b0; iv2 = 1'b1; id2 = 8'h05;
        tick();
        id2 = 8'h06;
        tick();
        f2 = 1'b1; id2 = 8'h0D; or2 = 1'b1;
        #1;
        n_cmp++; if (ir2 !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %0b exp 0", ir2); end
        n_cmp++; if (ov2 !== 1'b1 || od2 !== 8'h05) begin n_err++; $display("FAIL flush_delivered got valid=%0b data=%0h exp 1/05", ov2, od2); end
        tick();
        f2 = 1'b0; iv2 = 1'b0;
        n_cmp++; if (em2 !== 1'b1 || cn2 !== 2'd0) begin n_err++; $display("FAIL flush_empty got empty=%0b count=%0h exp 1/0", em2, cn2); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL flush_discard[%0d] got valid=%0b data=%0h exp valid 0", i, ov2, od2); end
        end
        or2 = 1'b0; iv2 = 1'b1; id2 = 8'h07;
        tick();
        id2 = 8'h09; f2 = 1'b1;
        #1;
        n_cmp++; if (ir2 !== 1'b0) begin n_err++; $display("FAIL flush_block_push got in_ready=%0b exp 0", ir2); end
        tick();
        f2 = 1'b0; id2 = 8'h03;
        n_cmp++; if (em2 !== 1'b1) begin n_err++; $display("FAIL flush_partial_empty got %0b exp 1", em2); end
        tick();
        iv2 = 1'b0;
        n_cmp++; if (ov2 !== 1'b1 || od2 !== 8'h03 || cn2 !== 2'd1) begin n_err++; $display("FAIL flush_restart got valid=%0b data=%0h count=%0h exp 1/03/1", ov2, od2, cn2); end
        or2 = 1'b1;
        tick();
        n_cmp++; if (em2 !== 1'b1) begin n_err++; $display("FAIL flush_restart_drain got %0b exp 1", em2); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [6:0] pat;
        int sent;
        int rcvd;
        logic do_push;
        logic do_pop;
        pat = 7'b1010011;
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 80 && rcvd < 10; c++) begin
            iv3 = (sent < 10);
            id3 = sent[7:0];
            or3 = pat[c % 7];
            #1;
            n_cmp++; if (ir3 !== (q.size() < 3)) begin n_err++; $display("FAIL wrap_in_ready[%0d] got %0b exp %0b", c, ir3, (q.size() < 3)); end
            n_cmp++; if (ov3 !== (q.size() != 0)) begin n_err++; $display("FAIL wrap_out_valid[%0d] got %0b exp %0b", c, ov3, (q.size() != 0)); end
            if (q.size() != 0) begin
                n_cmp++; if (od3 !== q[0]) begin n_err++; $display("FAIL wrap_data[%0d] got %0h exp %0h", c, od3, q[0]); end
            end
            do_pop  = or3 && (q.size() != 0);
            do_push = iv3 && (q.size() < 3);
            if (do_pop) begin
                void'(q.pop_front());
                rcvd++;
            end
            if (do_push) begin
                q.push_back(id3);
                sent++;
            end
            tick();
            n_cmp++; if (32'(cn3) !== q.size()) begin n_err++; $display("FAIL wrap_count[%0d] got %0d exp %0d", c, cn3, q.size()); end
        end
        iv3 = 1'b0;
        n_cmp++; if (rcvd !== 10) begin n_err++; $display("FAIL wrap_received got %0d exp 10", rcvd); end
    endtask

`ifdef PIPE_STAGE_BUF_STATS_EN
    task automatic test_stats();
        iv1 = 1'b1; id1 = 8'h55; or1 = 1'b0;
        tick();
        iv1 = 1'b0;
        n_cmp++; if (st1 !== 2'd0) begin n_err++; $display("FAIL stats_stall_start got %0d exp 0", st1); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++; if (st1 !== 2'((k < 3) ? k : 3)) begin n_err++; $display("FAIL stats_stall[%0d] got %0d exp %0d", k, st1, (k < 3) ? k : 3); end
        end
        f1 = 1'b1;
        tick();
        n_cmp++; if (fc1 !== 2'd1 || em1 !== 1'b1) begin n_err++; $display("FAIL stats_flush_count got %0d empty=%0b exp 1/1", fc1, em1); end
        tick();
        f1 = 1'b0;
        n_cmp++; if (fc1 !== 2'd1) begin n_err++; $display("FAIL stats_flush_empty got %0d exp 1", fc1); end
    endtask
`endif

    task automatic test_depth1();
        iv1 = 1'b1; or1 = 1'b1; id1 = 8'h40;
        for (int c = 0; c < 8; c++) begin
            n_cmp++; if (ir1 !== ((c % 2) == 0)) begin n_err++; $display("FAIL d1_in_ready[%0d] got %0b exp %0b", c, ir1, ((c % 2) == 0)); end
            n_cmp++; if (ov1 !== ((c % 2) == 1)) begin n_err++; $display("FAIL d1_out_valid[%0d] got %0b exp %0b", c, ov1, ((c % 2) == 1)); end
            if ((c % 2) == 1) begin
                n_cmp++; if (od1 !== 8'(64 + c / 2)) begin n_err++; $display("FAIL d1_data[%0d] got %0h exp %0h", c, od1, 64 + c / 2); end
            end
            tick();
            if ((c % 2) == 0) begin
                id1 = id1 + 8'h01;
            end
        end
        iv1 = 1'b0;
    endtask

    initial begin
        f2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; id2 = 8'h00;
        f3 = 1'b0; iv3 = 1'b0; or3 = 1'b0; id3 = 8'h00;
        f1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; id1 = 8'h00;
        test_reset();
        test_streaming();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_wrap();
`ifdef PIPE_STAGE_BUF_STATS_EN
        test_stats();
`endif
        test_depth1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers: one generic pipeline stage buffer with a valid/ready handshake.
- DEPTH-entry in-order buffer carrying an opaque DATA_W payload, such as a packed stage bundle of pc, control word, immediates and operands.
- Replaces the global en/flush stall scheme with per-stage backpressure, a flush, and an occupancy report.
- Sits between any two CPU pipeline stages.

Parameters:
DATA_W, 32, payload width in bits (>=1)
DEPTH, 2, number of entries (>=1; need not be a power of two)
CNT_W, 16, width of the statistics counters (optional feature only)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous discard of all contents
in_valid  input  1  producer offers in_data
in_ready  output  1  buffer can accept
in_data  input  DATA_W  producer payload
out_valid  output  1  out_data holds the oldest entry
out_ready  input  1  consumer accepts
out_data  output  DATA_W  oldest entry
count  output  $clog2(DEPTH+1)  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated at the rising edge.
- State:
  - storage array mem[DEPTH]
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide (minimum 1)
  - count register
- Pointer wrap: each pointer increments and wraps from DEPTH-1 to 0. Explicit compare is used, not modulo 2^n.
- in_ready = rst & !full & !flush. It has no combinational dependency on out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr]. empty and full are decoded from the count register only.
- Latency: a push at edge N gives out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Throughput:
  - DEPTH>=2 sustains one transfer per cycle.
  - DEPTH=1 sustains one transfer every 2 cycles, because in_ready is low whenever full.
- Simultaneous push and pop: count is unchanged, both pointers advance, and order is preserved. With count==DEPTH no push can occur, since in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Producer: may drop in_valid or change in_data at any time. Only handshaked beats are stored.
- flush=1 at an edge:
  - next state is count=0, wr_ptr=rd_ptr=0
  - any concurrent push is blocked (in_ready=0)
  - a concurrent pop is legal; that beat counts as delivered and the remaining entries are discarded
  - flush has priority over push and pop in the state update
- Reset (rst low, asynchronous, any time including mid-transfer):
  - count=0, both pointers=0, all mem entries=0
  - out_valid=0, out_data=0, empty=1, full=0
  - in_ready=0 while rst is low and 1 from the first cycle after release
- count never exceeds DEPTH and never underflows. A pop with count==0 cannot occur because out_valid=0.

Optional Feature:
- Macro: PIPE_STAGE_BUF_STATS_EN.
- When defined, two extra output ports are added:
  - stall_cycles [CNT_W-1:0]: increments each cycle with out_valid & !out_ready
  - flush_count [CNT_W-1:0]: increments each cycle with flush=1 and count!=0
- Both counters reset to 0 on rst low and saturate at all-ones; they do not wrap.
- When undefined, these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset mid-traffic: DEPTH=2 with 0x11 and 0x22 stored, pull rst low between edges -> immediately count=0, out_valid=0, out_data=0. After release in_ready=1, and neither 0x11 nor 0x22 ever appears.
- Streaming: DEPTH=2, out_ready=1, push 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 in order, each one cycle after its push, one per cycle, count steady at 1.
- Backpressure: out_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, full=1, in_ready=0, 0xC held off. Raise out_ready -> 0xA, 0xB, 0xC delivered in order, and out_data held 0xA unchanged throughout the stall.
- Push and pop when count=1: in=0xE while 0xD is popped -> count stays 1, next out_data=0xE.
- Flush: count=2 (0x5, 0x6), flush=1 with in_valid=1 and in_data=0xD -> in_ready=0 that cycle. Next cycle empty=1, and 0x6 and 0xD never emerge. If out_ready=1 during the flush cycle, exactly 0x5 is delivered.
- Wrap and DEPTH=1:
  - DEPTH=3 with random out_ready, 10 pushes 0x0..0x9 -> ordered output across pointer wrap, count never exceeds 3.
  - DEPTH=1 with constant valid and ready -> transfers on alternate cycles.
  - With PIPE_STAGE_BUF_STATS_EN and CNT_W=2: 5 stall cycles -> stall_cycles saturates at 3.
